decode_issue_ctrl: RTL and testbench

//  Decode-stage sequencer for the in-order pipeline. Holds one fetched instruction and feeds it to the combinational

---
 rtl/core_pkg.sv | 18 +
 rtl/decode_issue_ctrl_reg_scoreboard.sv | 71 +++++++
 rtl/decode_issue_ctrl.sv | 94 +++++++++
 tb/tb_decode_issue_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared decode-stage definitions: opcode encodings, issue FSM states, register index width.
package core_pkg;

  localparam int REG_W = 5;

  localparam logic [6:0] OP_ALU    = 7'h33;
  localparam logic [6:0] OP_ALUIMM = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_JB     = 7'h63;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HELD  = 2'd1,
    ST_TRAP  = 2'd2
  } issue_state_t;

endpackage

// File: rtl/decode_issue_ctrl_reg_scoreboard.sv
// Pending-write scoreboard: busy bit per register plus outstanding-writer count.
// Optional macro WB_BYPASS_EN lets a same-cycle writeback release busy/count for the hazard lookup.
module reg_scoreboard
  import core_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_rd,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rd_busy,
  output logic             full
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      busy_q, busy_d, busy_vis;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_vis;
  logic             set_ok, clr_ok;

  assign set_ok = set_en && (set_rd != '0);
  assign clr_ok = clr_en && (clr_rd != '0);

  // Clear before set so a same-register set in the same cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_ok) busy_d[clr_rd] = 1'b0;
    if (set_ok) busy_d[set_rd] = 1'b1;
    cnt_d = cnt_q;
    if (set_ok && !clr_ok)      cnt_d = cnt_q + 1'b1;
    else if (clr_ok && !set_ok) cnt_d = cnt_q - 1'b1;
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    busy_vis = busy_q;
    if (clr_ok) busy_vis[clr_rd] = 1'b0;
    cnt_vis = clr_ok ? (cnt_q - 1'b1) : cnt_q;
  end
`else
  always_comb begin
    busy_vis = busy_q;
    cnt_vis  = cnt_q;
  end
`endif

  assign rs1_busy = busy_vis[rs1];
  assign rs2_busy = busy_vis[rs2];
  assign rd_busy  = busy_vis[rd];
  assign full     = (cnt_vis == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage sequencer: holds one instruction, stalls on RAW/WAW via the scoreboard, issues with valid/ready.
// Build option WB_BYPASS_EN (see reg_scoreboard) shortens a writeback dependence by one cycle.
module decode_issue_ctrl
  import core_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int XLEN            = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_inst,
  output logic             if_ready,
  output logic [XLEN-1:0]  dec_inst,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic [REG_W-1:0] dec_rd,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic             dec_wr_rd,
  input  logic             dec_illegal,
  output logic             ex_valid,
  input  logic             ex_ready,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             flush,
  output logic             illegal_trap
);

  issue_state_t    state_q;
  logic [XLEN-1:0] inst_q;
  logic            rs1_busy, rs2_busy, rd_busy, full;
  logic            haz, fire;

  reg_scoreboard #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (fire && dec_wr_rd),
    .set_rd   (dec_rd),
    .clr_en   (wb_valid),
    .clr_rd   (wb_rd),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .full     (full)
  );

  always_comb begin
    haz = (dec_use_rs1 && (dec_rs1 != '0) && rs1_busy) ||
          (dec_use_rs2 && (dec_rs2 != '0) && rs2_busy) ||
          (dec_wr_rd   && (dec_rd  != '0) && (rd_busy || full));
  end

  // Flush and reset suppress every handshake in the cycle they are asserted.
  assign ex_valid     = !rst && !flush && (state_q == ST_HELD) && !dec_illegal && !haz;
  assign fire         = ex_valid && ex_ready;
  assign if_ready     = !rst && !flush && ((state_q == ST_EMPTY) || fire);
  assign illegal_trap = !rst && !flush && (state_q == ST_TRAP);
  assign dec_inst     = inst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      inst_q  <= '0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (if_valid) begin
            inst_q  <= if_inst;
            state_q <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (dec_illegal) begin
            state_q <= ST_TRAP;
          end else if (fire) begin
            if (if_valid) inst_q  <= if_inst;
            else          state_q <= ST_EMPTY;
          end
        end
        ST_TRAP: state_q <= ST_EMPTY;
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Randomized bench for decode_issue_ctrl with an instruction-level reference model and issue scoreboard.
module tb_decode_issue_ctrl;
  import core_pkg::*;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready, ex_valid, ex_ready, wb_valid, flush, illegal_trap;
  logic [31:0] if_inst, dec_inst;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic        dec_use_rs1, dec_use_rs2, dec_wr_rd, dec_illegal;

  always #5 clk = ~clk;

  decode_issue_ctrl #(.MAX_OUTSTANDING(MAXO), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_ready(if_ready),
    .dec_inst(dec_inst), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_wr_rd(dec_wr_rd),
    .dec_illegal(dec_illegal), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .illegal_trap(illegal_trap)
  );

  typedef struct packed {
    logic       u1, u2, wr, ill;
    logic [4:0] rs1, rs2, rd;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    d = '0;
    d.rd = i[11:7]; d.rs1 = i[19:15]; d.rs2 = i[24:20];
    case (i[6:0])
      OP_ALU:                  begin d.u1 = 1; d.u2 = 1; d.wr = 1; end
      OP_ALUIMM, OP_LOAD:      begin d.u1 = 1; d.wr = 1; end
      OP_STORE, OP_JB:         begin d.u1 = 1; d.u2 = 1; end
      default:                 d.ill = 1;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  // Decoder model driven from the held instruction.
  dec_t dd;
  always_comb begin
    dd          = decode(dec_inst);
    dec_rs1     = dd.rs1;
    dec_rs2     = dd.rs2;
    dec_rd      = dd.rd;
    dec_use_rs1 = dd.u1;
    dec_use_rs2 = dd.u2;
    dec_wr_rd   = dd.wr;
    dec_illegal = dd.ill;
  end

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int          n_vec = 0, n_err = 0;
  int          m_st = 0;            // 0 empty, 1 holding, 2 trap pulse pending
  logic [31:0] m_inst = '0;
  logic [4:0]  infl[$];             // destinations written by issued, not yet retired instructions
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit reg_busy(input logic [4:0] r);
    if (BYP && wb_valid && wb_rd == r) return 1'b0;
    foreach (infl[k]) if (infl[k] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cycle(input logic iv, input logic [31:0] inst, input logic exr,
                       input logic wbv, input logic [4:0] wbr, input logic fl);
    dec_t d;
    int   cnt;
    bit   haz, e_v, e_r, e_t, iss;
    if_valid = iv; if_inst = inst; ex_ready = exr; wb_valid = wbv; wb_rd = wbr; flush = fl;
    @(negedge clk);
    d   = decode(m_inst);
    cnt = infl.size() - ((BYP && wbv && wbr != 0) ? 1 : 0);
    haz = (d.u1 && d.rs1 != 0 && reg_busy(d.rs1)) || (d.u2 && d.rs2 != 0 && reg_busy(d.rs2)) ||
          (d.wr && d.rd != 0 && (reg_busy(d.rd) || cnt == MAXO));
    e_v = !fl && m_st == 1 && !d.ill && !haz;
    iss = e_v && exr;
    e_r = !fl && (m_st == 0 || iss);
    e_t = !fl && m_st == 2;
    chk("ex_valid", 32'(ex_valid), 32'(e_v));
    chk("if_ready", 32'(if_ready), 32'(e_r));
    chk("illegal_trap", 32'(illegal_trap), 32'(e_t));
    if (m_st == 1) chk("dec_inst", dec_inst, m_inst);
    if (iss) exp_q.push_back(m_inst);
    if (wbv && wbr != 0)
      for (int k = 0; k < infl.size(); k++)
        if (infl[k] == wbr) begin infl.delete(k); break; end
    if (iss && d.wr && d.rd != 0) infl.push_back(d.rd);
    if (fl) m_st = 0;
    else case (m_st)
      0: if (iv) begin m_st = 1; m_inst = inst; end
      1: if (d.ill) m_st = 2;
         else if (iss) begin
           if (iv) m_inst = inst; else m_st = 0;
         end
      default: m_st = 0;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_valid = $urandom_range(0, 1); ex_ready = $urandom_range(0, 1);
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0; if_inst = $urandom;
    @(negedge clk);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_trap", 32'(illegal_trap), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_st = 0; infl.delete();
    chk("rst_dec_inst", dec_inst, 32'd0);
  endtask

  // Issue monitor: every accepted issue must be the next expected instruction.
  always @(negedge clk) begin
    #1;
    if (ex_valid && ex_ready) begin
      if (exp_q.size() == 0) chk("issue_unexpected", dec_inst, 32'hxxxx_xxxx);
      else chk("issue_inst", dec_inst, exp_q.pop_front());
    end
  end

  function automatic logic [31:0] rnd_inst();
    logic [6:0] op;
    case ($urandom_range(0, 9))
      0, 1, 2: op = OP_ALU;
      3, 4:    op = OP_ALUIMM;
      5:       op = OP_LOAD;
      6:       op = OP_STORE;
      7:       op = OP_JB;
      8:       op = 7'h7F;
      default: op = 7'h00;
    endcase
    return mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
  endfunction

  initial begin
    rst = 1'b1; if_valid = 0; if_inst = '0; ex_ready = 0; wb_valid = 0; wb_rd = '0; flush = 0;
    @(posedge clk); #1;
    do_reset();

    // Independent back-to-back adds
    cycle(1, mk(OP_ALU, 1, 2, 3), 1, 0, 0, 0);
    cycle(1, mk(OP_ALU, 4, 5, 6), 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 1, 1, 0);
    cycle(0, '0, 1, 1, 4, 0);
    // RAW on x5 released by writeback
    cycle(1, mk(OP_ALU, 5, 1, 2), 1, 0, 0, 0);
    cycle(1, mk(OP_ALU, 6, 5, 7), 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 1, 5, 0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 1, 6, 0);
    // x0-only stream never stalls
    for (int i = 0; i < 6; i++) cycle(1, mk(OP_ALUIMM, 0, 0, 0), 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);
    // Illegal opcode trap
    cycle(1, 32'h0000_007F, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 0, 0);
    // Flush while stalled; busy x3 survives the flush
    cycle(1, mk(OP_ALU, 3, 0, 0), 1, 0, 0, 0);
    cycle(1, mk(OP_ALU, 8, 3, 0), 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 1);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(1, mk(OP_ALU, 9, 3, 0), 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 1, 3, 0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 1, 9, 0);
    // Outstanding-writer limit
    cycle(1, mk(OP_ALU, 1, 0, 0), 1, 0, 0, 0);
    cycle(1, mk(OP_ALU, 2, 0, 0), 1, 0, 0, 0);
    cycle(1, mk(OP_ALU, 3, 0, 0), 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 1, 1, 0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 1, 2, 0);
    cycle(0, '0, 1, 1, 3, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else begin
        logic       wv;
        logic [4:0] wr;
        wv = 0; wr = '0;
        if (infl.size() > 0 && $urandom_range(0, 2) == 0) begin
          wv = 1; wr = infl[$urandom_range(0, infl.size() - 1)];
        end else if ($urandom_range(0, 9) == 0) wv = 1;
        cycle(1'($urandom_range(0, 3) != 0), rnd_inst(), 1'($urandom_range(0, 3) != 0),
              wv, wr, 1'($urandom_range(0, 24) == 0));
      end
    end

    cycle(0, '0, 0, 0, 0, 0);
    chk("exp_q_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
